fft_in_pingpong: RTL and testbench

//   Ping-pong frame buffer sitting directly upstream of the FFT128 processor input bus.
//   - Accepts a streamed sample source (valid/ready) and assembles 128-sample frames into two banks.
//   - Serves the processor's one-hot input requests: data port pops the next sample; status port reports buffer state.
//   - Raises a one-cycle interrupt (itr) each time a frame becomes readable.

---
 rtl/fft_io_pkg.sv | 28 ++
 rtl/fft_bank_ctl.sv | 36 +++
 rtl/fft_in_pingpong.sv | 142 ++++++++++++++
 tb/tb_fft_in_pingpong.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_io_pkg.sv
// Shared definitions for the FFT128 input-side buffering: bank states,
// status word layout and the processor I/O word width.
package fft_io_pkg;

    localparam int NB_IO = 23;

    // Status word bit positions
    localparam int STA_AVAIL = 0;
    localparam int STA_UNDR  = 1;
    localparam int STA_BANK  = 2;
    localparam int STA_IDX   = 3;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2,
        READING = 2'd3
    } bank_state_e;

    function automatic logic bank_writable(input bank_state_e s);
        return (s == EMPTY) || (s == FILLING);
    endfunction

    function automatic logic bank_readable(input bank_state_e s);
        return (s == FULL) || (s == READING);
    endfunction

endpackage

// File: rtl/fft_bank_ctl.sv
// Per-bank lifecycle tracker: EMPTY -> FILLING -> FULL -> READING -> EMPTY.
// Exposes both the registered state and its next-state value.
module fft_bank_ctl
    import fft_io_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        wr_last,
    input  logic        rd_en,
    input  logic        rd_last,
    output bank_state_e state,
    output bank_state_e state_nxt
);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (wr_en) state_nxt = wr_last ? FULL : FILLING;
            FILLING: if (wr_en && wr_last) state_nxt = FULL;
            FULL:    if (rd_en) state_nxt = rd_last ? EMPTY : READING;
            READING: if (rd_en && rd_last) state_nxt = EMPTY;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

endmodule

// File: rtl/fft_in_pingpong.sv
// Ping-pong frame buffer feeding the FFT128 processor input bus: streams samples
// into two banks, serves one-hot data/status requests and flags each full frame.
module fft_in_pingpong
    import fft_io_pkg::*;
#(
    parameter int NB_IN    = 12,
    parameter int FFTN     = 128,
    parameter int NUIOIN   = 5,
    parameter int PORT_DAT = 0,
    parameter int PORT_STA = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [NB_IN-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [NUIOIN-1:0]       req_in,
    output logic [NB_IO-1:0]        io_in,
    output logic                    itr
);

    localparam int IDXW = $clog2(FFTN);

    logic [IDXW-1:0]  wr_idx;
    logic [IDXW-1:0]  rd_idx;
    logic             wr_bank;
    logic             rd_bank;
    logic             underrun;
    logic [NB_IO-1:0] mem [2][FFTN];

    bank_state_e      st     [2];
    bank_state_e      st_nxt [2];
    logic [1:0]       bank_wr_en;
    logic [1:0]       bank_rd_en;

    logic             wr_fire;
    logic             wr_last;
    logic             wr_bank_nxt;
    logic             s_ready_nxt;
    logic             rd_last;
    logic             rd_avail;
    logic             sta_req;
    logic             dat_req;
    logic             pop;
    logic             undr_set;
    logic [NB_IO-1:0] sample_ext;
    logic [NB_IO-1:0] status;
    logic             unused_req;

    // Request bits other than the data and status ports carry no meaning here.
    assign unused_req = ^req_in;

    assign sample_ext  = NB_IO'(s_data);
    assign wr_fire     = s_valid & s_ready;
    assign wr_last     = (wr_idx == IDXW'(FFTN - 1));
    assign wr_bank_nxt = wr_bank ^ (wr_fire & wr_last);

    assign rd_avail = bank_readable(st[rd_bank]);
    assign rd_last  = (rd_idx == IDXW'(FFTN - 1));
    assign sta_req  = req_in[PORT_STA];
    // A status request masks a simultaneous data request, so nothing is popped.
    assign dat_req  = req_in[PORT_DAT] & ~sta_req;
    assign pop      = dat_req & rd_avail;
    assign undr_set = dat_req & ~rd_avail;

    always_comb begin
        bank_wr_en[0] = wr_fire & ~wr_bank;
        bank_wr_en[1] = wr_fire &  wr_bank;
        bank_rd_en[0] = pop & ~rd_bank;
        bank_rd_en[1] = pop &  rd_bank;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_bank_ctl u_ctl (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (bank_wr_en[b]),
            .wr_last   (wr_last),
            .rd_en     (bank_rd_en[b]),
            .rd_last   (rd_last),
            .state     (st[b]),
            .state_nxt (st_nxt[b])
        );
    end

    // Ready looks ahead so a bank released this cycle is writable on the next one.
    assign s_ready_nxt = bank_writable(st_nxt[wr_bank_nxt]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_idx   <= '0;
            rd_idx   <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            underrun <= 1'b0;
            s_ready  <= 1'b0;
            itr      <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_idx <= wr_idx + IDXW'(1);
            end
            wr_bank <= wr_bank_nxt;
            if (pop) begin
                rd_idx <= rd_idx + IDXW'(1);
                if (rd_last) begin
                    rd_bank <= ~rd_bank;
                end
            end
            if (undr_set) begin
                underrun <= 1'b1;
            end else if (sta_req) begin
                underrun <= 1'b0;
            end
            itr     <= wr_fire & wr_last;
            s_ready <= s_ready_nxt;
        end
    end

    // NOTE: sample storage has no reset; bank states gate every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_bank][wr_idx] <= sample_ext;
        end
    end

    always_comb begin
        status                 = '0;
        status[STA_AVAIL]      = rd_avail;
        status[STA_UNDR]       = underrun;
        status[STA_BANK]       = rd_bank;
        status[STA_IDX +: IDXW] = rd_idx;

        if (sta_req) begin
            io_in = status;
        end else if (rd_avail) begin
            io_in = mem[rd_bank][rd_idx];
        end else begin
            io_in = '0;
        end
    end

endmodule

// File: tb/tb_fft_in_pingpong.sv
// Directed self-checking bench for fft_in_pingpong: streaming, sign extension,
// backpressure, underrun, simultaneous bank handover and mid-frame reset.
module tb_fft_in_pingpong;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [11:0] s_data;
    logic               s_valid;
    logic               s_ready;
    logic [4:0]         req_in;
    logic [22:0]        io_in;
    logic               itr;

    int tests_run    = 0;
    int tests_failed = 0;
    int itr_cnt      = 0;

    always #5 clk = ~clk;

    fft_in_pingpong #(
        .NB_IN    (12),
        .FFTN     (128),
        .NUIOIN   (5),
        .PORT_DAT (0),
        .PORT_STA (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .req_in  (req_in),
        .io_in   (io_in),
        .itr     (itr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (itr) itr_cnt++;
    endtask

    task automatic write_sample(input logic [11:0] v);
        int budget;
        budget  = 400;
        s_data  = v;
        s_valid = 1'b1;
        while (!s_ready && budget > 0) begin
            tick();
            budget--;
        end
        if (!s_ready) check("wr_wait_ready", {31'b0, s_ready}, 32'd1);
        tick();
    endtask

    task automatic stream(input int start, input int n);
        for (int k = 0; k < n; k++) write_sample(12'(start + k));
        s_valid = 1'b0;
    endtask

    task automatic pop_frame(input int start, input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            req_in = 5'b00001;
            #1;
            check(tag, {9'b0, io_in}, 32'(start + k));
            tick();
        end
        req_in = '0;
    endtask

    task automatic status_read(input logic [22:0] exp, input string tag);
        req_in = 5'b00010;
        #1;
        check(tag, {9'b0, io_in}, {9'b0, exp});
        tick();
        req_in = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b0;
        s_data  = '0;
        s_valid = 1'b0;
        req_in  = '0;

        // Reset state
        #3;
        check("rst_s_ready", {31'b0, s_ready}, 32'd0);
        check("rst_itr", {31'b0, itr}, 32'd0);
        check("rst_io_in", {9'b0, io_in}, 32'd0);
        tick();
        check("rst_s_ready_held", {31'b0, s_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("ready_after_rst", {31'b0, s_ready}, 32'd1);

        // 1: one frame 0..127, itr timing, ordered readback
        itr_cnt = 0;
        for (int k = 0; k < 128; k++) begin
            write_sample(12'(k));
            if (k == 126) check("t1_no_early_itr", itr_cnt, 0);
        end
        s_valid = 1'b0;
        check("t1_itr_after_last", {31'b0, itr}, 32'd1);
        tick();
        check("t1_itr_one_cycle", {31'b0, itr}, 32'd0);
        check("t1_itr_count", itr_cnt, 1);
        status_read(23'h000001, "t1_status_full");
        pop_frame(0, 128, "t1_pop");
        status_read(23'h000004, "t1_status_empty");

        // 2: sign extension of extreme samples (bank 1)
        write_sample(12'h800);
        write_sample(12'h7FF);
        stream(2, 126);
        req_in = 5'b00000;
        #1;
        check("t2_peek_neg", {9'b0, io_in}, 32'h007FF800);
        req_in = 5'b00001;
        #1;
        check("t2_pop_neg", {9'b0, io_in}, 32'h007FF800);
        tick();
        #1;
        check("t2_pop_pos", {9'b0, io_in}, 32'h000007FF);
        tick();
        pop_frame(2, 126, "t2_pop");

        // 3: two frames without popping -> backpressure, then release
        itr_cnt = 0;
        stream(0, 256);
        check("t3_ready_low", {31'b0, s_ready}, 32'd0);
        check("t3_itr_count", itr_cnt, 2);
        status_read(23'h000001, "t3_status_b0");
        pop_frame(0, 128, "t3_pop_b0");
        check("t3_ready_reassert", {31'b0, s_ready}, 32'd1);
        itr_cnt = 0;
        stream(256, 128);
        check("t3_itr_refill", itr_cnt, 1);
        status_read(23'h000005, "t3_status_b1");
        pop_frame(128, 128, "t3_pop_b1");
        pop_frame(256, 128, "t3_pop_b0_new");

        // 4: underrun is sticky until a status read
        req_in = 5'b00001;
        #1;
        check("t4_underrun_io", {9'b0, io_in}, 32'd0);
        tick();
        req_in = '0;
        status_read(23'h000006, "t4_status_undr");
        status_read(23'h000004, "t4_status_clear");

        // 5: final write of bank1 and final pop of bank0 in one cycle
        stream(500, 128);
        stream(700, 128);
        check("t5_ready_low", {31'b0, s_ready}, 32'd0);
        pop_frame(500, 128, "t5_pop_b1");
        check("t5_ready_b1", {31'b0, s_ready}, 32'd1);
        for (int k = 0; k < 127; k++) begin
            s_data  = 12'(900 + k);
            s_valid = 1'b1;
            req_in  = 5'b00001;
            #1;
            check("t5_pop_b0", {9'b0, io_in}, 32'(700 + k));
            tick();
        end
        s_data = 12'(1027);
        #1;
        check("t5_pop_b0_last", {9'b0, io_in}, 32'd827);
        tick();
        s_valid = 1'b0;
        req_in  = '0;
        check("t5_itr", {31'b0, itr}, 32'd1);
        check("t5_ready", {31'b0, s_ready}, 32'd1);
        status_read(23'h000005, "t5_status");

        // Both request bits: status wins, no pop; unrelated bit shows data
        req_in = 5'b00011;
        #1;
        check("t5_both_status", {9'b0, io_in}, 32'h00000005);
        tick();
        req_in = 5'b00100;
        #1;
        check("t5_other_bit_data", {9'b0, io_in}, 32'd900);
        tick();
        req_in = '0;
        status_read(23'h000005, "t5_no_pop");

        // 6: asynchronous reset mid-fill and mid-read
        for (int k = 0; k < 70; k++) begin
            req_in = 5'b00001;
            if (k < 50) begin
                s_data  = 12'(1100 + k);
                s_valid = 1'b1;
            end else begin
                s_valid = 1'b0;
            end
            #1;
            check("t6_pop_partial", {9'b0, io_in}, 32'(900 + k));
            tick();
        end
        req_in  = '0;
        s_valid = 1'b0;
        status_read(23'h000235, "t6_status_mid");
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_ready", {31'b0, s_ready}, 32'd0);
        check("t6_rst_itr", {31'b0, itr}, 32'd0);
        check("t6_rst_io", {9'b0, io_in}, 32'd0);
        req_in = 5'b00010;
        #1;
        check("t6_rst_status", {9'b0, io_in}, 32'd0);
        req_in = '0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("t6_ready_after", {31'b0, s_ready}, 32'd1);
        itr_cnt = 0;
        stream(1200, 128);
        check("t6_itr_fresh", itr_cnt, 1);
        status_read(23'h000001, "t6_status_fresh");
        pop_frame(1200, 128, "t6_pop_fresh");
        status_read(23'h000004, "t6_status_done");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
